// File: rtl/axi_rd_slave.sv
// AXI read-channel responder (AR/R) for the instruction/data memory.
// Accepts one AR request at a time, waits LATENCY cycles, then performs one
// synchronous memory read per beat and returns INCR/FIXED bursts on R with
// OKAY/SLVERR/DECERR responses.
module axi_rd_slave #(
  parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
  parameter logic [63:0] MEM_BYTES = 64'h0800_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  ARID,
  input  logic [63:0] ARADDR,
  input  logic [7:0]  ARLEN,
  input  logic [2:0]  ARSIZE,
  input  logic [1:0]  ARBURST,
  input  logic [2:0]  ARPORT,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [3:0]  RID,
  output logic [63:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY,
  output logic        mem_ren,
  output logic [63:0] mem_addr,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FETCH = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [7:0]  LAT8   = 8'(LATENCY);
  localparam logic [64:0] WIN_LO = {1'b0, ADDR_BASE};
  localparam logic [64:0] WIN_HI = {1'b0, ADDR_BASE} + {1'b0, MEM_BYTES};

  state_t      r_state;
  state_t      w_next;
  logic        r_arready;
  logic [3:0]  r_id;
  logic [63:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [2:0]  r_prot;
  logic [7:0]  r_beat;
  logic [7:0]  r_cnt;
  logic        r_entry;
  logic [63:0] r_rdata;

  logic        w_arHs;
  logic        w_last;
  logic        w_inWin;
  logic        w_slverr;
  logic [1:0]  w_resp;
  logic [63:0] w_live;
  logic [63:0] w_nbytes;
  logic [63:0] w_nextAddr;
  logic        w_unusedProt;

  // Per-beat decode: response code, burst end, data seen on entry to RESP and the INCR step.
  always_comb begin
    w_arHs       = ARVALID && r_arready;
    w_last       = (r_beat == r_len);
    w_inWin      = ({1'b0, r_addr} >= WIN_LO) && ({1'b0, r_addr} < WIN_HI);
    w_slverr     = r_burst[1] || (r_size > 3'd3);
    w_resp       = 2'b00;
    if (w_slverr) begin
      w_resp = 2'b10;
    end else if (!w_inWin) begin
      w_resp = 2'b11;
    end
    w_live       = (w_resp == 2'b00) ? mem_rdata : 64'd0;
    w_nbytes     = 64'd1 << r_size;
    w_nextAddr   = (r_addr & ~(w_nbytes - 64'd1)) + w_nbytes;
    w_unusedProt = ^r_prot;
  end

  // Next-state logic for the single-outstanding read sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_arHs) begin
          w_next = (LATENCY == 0) ? S_FETCH : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt <= 8'd1) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        if (RREADY) begin
          w_next = w_last ? S_IDLE : S_FETCH;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register; a reset mid-burst drops straight back to IDLE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request capture, latency counter, beat/address advance and R data holding.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_arready <= 1'b0;
      r_id      <= 4'd0;
      r_addr    <= 64'd0;
      r_len     <= 8'd0;
      r_size    <= 3'd0;
      r_burst   <= 2'b00;
      r_prot    <= 3'd0;
      r_beat    <= 8'd0;
      r_cnt     <= 8'd0;
      r_entry   <= 1'b0;
      r_rdata   <= 64'd0;
    end else begin
      r_arready <= (w_next == S_IDLE);
      r_entry   <= (r_state == S_FETCH);
      case (r_state)
        S_IDLE: begin
          if (w_arHs) begin
            r_id    <= ARID;
            r_addr  <= ARADDR;
            r_len   <= ARLEN;
            r_size  <= ARSIZE;
            r_burst <= ARBURST;
            r_prot  <= ARPORT;
            r_beat  <= 8'd0;
            r_cnt   <= LAT8;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 8'd1;
        end
        S_RESP: begin
          if (r_entry) begin
            r_rdata <= w_live;
          end
          if (RREADY && !w_last) begin
            r_beat <= r_beat + 8'd1;
            if (r_burst == 2'b01) begin
              r_addr <= w_nextAddr;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Memory read data is only valid in the first RESP cycle, so it is shown live
  // then and held from the register for the rest of a stalled beat.
  assign ARREADY  = r_arready;
  assign RID      = r_id;
  assign RVALID   = (r_state == S_RESP);
  assign RLAST    = (r_state == S_RESP) && w_last;
  assign RRESP    = (r_state == S_RESP) ? w_resp : 2'b00;
  assign RDATA    = ((r_state == S_RESP) && r_entry) ? w_live : r_rdata;
  assign mem_ren  = (r_state == S_FETCH) && (w_resp == 2'b00);
  assign mem_addr = {r_addr[63:3], 3'b000};

endmodule

// File: tb/tb_axi_rd_slave.sv
// Directed self-checking bench for axi_rd_slave (LATENCY=2).
module tb_axi_rd_slave;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  ARID;
  logic [63:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [2:0]  ARPORT;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        mem_ren;
  logic [63:0] mem_addr;
  logic [63:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  axi_rd_slave #(
    .ADDR_BASE(64'h8000_0000),
    .MEM_BYTES(64'h0800_0000),
    .LATENCY  (2)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .ARID     (ARID),
    .ARADDR   (ARADDR),
    .ARLEN    (ARLEN),
    .ARSIZE   (ARSIZE),
    .ARBURST  (ARBURST),
    .ARPORT   (ARPORT),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .RID      (RID),
    .RDATA    (RDATA),
    .RRESP    (RRESP),
    .RLAST    (RLAST),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .mem_ren  (mem_ren),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Memory contents as a fixed function of the doubleword address.
  function automatic logic [63:0] memFn(input logic [63:0] a);
    if (a == 64'h8000_0000) begin
      return 64'h1122_3344_5566_7788;
    end
    return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
  endfunction

  // Synchronous memory: data valid the cycle after a read strobe, junk otherwise.
  always @(posedge clk) begin
    if (mem_ren) begin
      mem_rdata <= memFn(mem_addr);
    end else begin
      mem_rdata <= {$urandom, $urandom};
    end
  end

  // Hard stop in case the sequence ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one AR request and return one cycle after the handshake edge.
  task automatic applyStimulus(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
    int n;
    ARID    = id;
    ARADDR  = addr;
    ARLEN   = len;
    ARSIZE  = size;
    ARBURST = burst;
    ARPORT  = 3'b010;
    ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("ar_ready_wait", 64'(ARREADY), 64'd1);
    tick();
    ARVALID = 1'b0;
  endtask

  logic [63:0] t2Addr [4];

  // Directed sequence covering the listed scenarios.
  initial begin
    t2Addr = '{64'h8000_0010, 64'h8000_0018, 64'h8000_0020, 64'h8000_0028};
    rstn = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
    ARID = 4'd0; ARADDR = 64'd0; ARLEN = 8'd0; ARSIZE = 3'd0; ARBURST = 2'b00; ARPORT = 3'd0;
    tick(); tick();
    checkOutput("rst_arready", 64'(ARREADY), 64'd0);
    checkOutput("rst_rvalid",  64'(RVALID),  64'd0);
    checkOutput("rst_rlast",   64'(RLAST),   64'd0);
    checkOutput("rst_rresp",   64'(RRESP),   64'd0);
    checkOutput("rst_rid",     64'(RID),     64'd0);
    checkOutput("rst_rdata",   RDATA,        64'd0);
    checkOutput("rst_memren",  64'(mem_ren), 64'd0);
    rstn = 1'b1;
    tick();
    checkOutput("rel_arready", 64'(ARREADY), 64'd1);

    // 1: single beat, latency timing
    applyStimulus(4'd3, 64'h8000_0004, 8'd0, 3'd2, 2'b01);
    checkOutput("t1_arready_drop", 64'(ARREADY), 64'd0);
    checkOutput("t1_c1_memren", 64'(mem_ren), 64'd0);
    tick();
    checkOutput("t1_c2_memren", 64'(mem_ren), 64'd0);
    tick();
    checkOutput("t1_c3_memren", 64'(mem_ren), 64'd1);
    checkOutput("t1_c3_addr", mem_addr, 64'h8000_0000);
    checkOutput("t1_c3_rvalid", 64'(RVALID), 64'd0);
    tick();
    checkOutput("t1_c4_rvalid", 64'(RVALID), 64'd1);
    checkOutput("t1_rdata", RDATA, 64'h1122_3344_5566_7788);
    checkOutput("t1_rresp", 64'(RRESP), 64'd0);
    checkOutput("t1_rlast", 64'(RLAST), 64'd1);
    checkOutput("t1_rid", 64'(RID), 64'd3);
    RREADY = 1'b1;
    tick();
    checkOutput("t1_end_rvalid", 64'(RVALID), 64'd0);
    checkOutput("t1_end_arready", 64'(ARREADY), 64'd1);

    // 2: four-beat INCR doubleword burst with RREADY held high
    applyStimulus(4'd5, 64'h8000_0010, 8'd3, 3'd3, 2'b01);
    tick(); tick();
    for (int b = 0; b < 4; b++) begin
      checkOutput("t2_memren", 64'(mem_ren), 64'd1);
      checkOutput("t2_addr", mem_addr, t2Addr[b]);
      checkOutput("t2_rvalid_lo", 64'(RVALID), 64'd0);
      tick();
      checkOutput("t2_rvalid_hi", 64'(RVALID), 64'd1);
      checkOutput("t2_rlast", 64'(RLAST), (b == 3) ? 64'd1 : 64'd0);
      checkOutput("t2_rdata", RDATA, memFn(t2Addr[b]));
      checkOutput("t2_rresp", 64'(RRESP), 64'd0);
      checkOutput("t2_arready_busy", 64'(ARREADY), 64'd0);
      tick();
    end
    checkOutput("t2_arready_back", 64'(ARREADY), 64'd1);
    checkOutput("t2_rvalid_end", 64'(RVALID), 64'd0);

    // 3: stall five cycles in RESP, then release
    RREADY = 1'b0;
    applyStimulus(4'd7, 64'h8000_0100, 8'd1, 3'd3, 2'b01);
    tick(); tick(); tick();
    checkOutput("t3_entry_rdata", RDATA, memFn(64'h8000_0100));
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t3_hold_rvalid", 64'(RVALID), 64'd1);
      checkOutput("t3_hold_rdata", RDATA, memFn(64'h8000_0100));
      checkOutput("t3_hold_rlast", 64'(RLAST), 64'd0);
      checkOutput("t3_hold_memren", 64'(mem_ren), 64'd0);
    end
    RREADY = 1'b1;
    tick();
    checkOutput("t3_next_memren", 64'(mem_ren), 64'd1);
    checkOutput("t3_next_addr", mem_addr, 64'h8000_0108);
    tick();
    checkOutput("t3_b1_rdata", RDATA, memFn(64'h8000_0108));
    checkOutput("t3_b1_rlast", 64'(RLAST), 64'd1);
    tick();
    checkOutput("t3_arready", 64'(ARREADY), 64'd1);

    // 4a: address below window -> DECERR, no memory access
    RREADY = 1'b0;
    applyStimulus(4'd1, 64'h0000_1000, 8'd0, 3'd3, 2'b01);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t4a_memren", 64'(mem_ren), 64'd0);
      tick();
    end
    checkOutput("t4a_rvalid", 64'(RVALID), 64'd1);
    checkOutput("t4a_rresp", 64'(RRESP), 64'd3);
    checkOutput("t4a_rdata", RDATA, 64'd0);
    checkOutput("t4a_rlast", 64'(RLAST), 64'd1);
    checkOutput("t4a_memren_resp", 64'(mem_ren), 64'd0);
    RREADY = 1'b1;
    tick();
    checkOutput("t4a_arready", 64'(ARREADY), 64'd1);

    // 4b: burst crossing the top of the window
    applyStimulus(4'd2, 64'h87FF_FFF8, 8'd1, 3'd3, 2'b01);
    tick(); tick();
    checkOutput("t4b_b0_memren", 64'(mem_ren), 64'd1);
    checkOutput("t4b_b0_addr", mem_addr, 64'h87FF_FFF8);
    tick();
    checkOutput("t4b_b0_rresp", 64'(RRESP), 64'd0);
    checkOutput("t4b_b0_rlast", 64'(RLAST), 64'd0);
    checkOutput("t4b_b0_rdata", RDATA, memFn(64'h87FF_FFF8));
    tick();
    checkOutput("t4b_b1_memren", 64'(mem_ren), 64'd0);
    tick();
    checkOutput("t4b_b1_rvalid", 64'(RVALID), 64'd1);
    checkOutput("t4b_b1_rresp", 64'(RRESP), 64'd3);
    checkOutput("t4b_b1_rlast", 64'(RLAST), 64'd1);
    checkOutput("t4b_b1_rdata", RDATA, 64'd0);
    tick();
    checkOutput("t4b_arready", 64'(ARREADY), 64'd1);

    // 5: unsupported burst type -> SLVERR on all beats, AR ignored while busy
    applyStimulus(4'd4, 64'h8000_0000, 8'd2, 3'd3, 2'b10);
    ARID = 4'd9; ARVALID = 1'b1;
    checkOutput("t5_arready_c1", 64'(ARREADY), 64'd0);
    tick(); tick();
    for (int b = 0; b < 3; b++) begin
      checkOutput("t5_memren", 64'(mem_ren), 64'd0);
      checkOutput("t5_arready_fetch", 64'(ARREADY), 64'd0);
      tick();
      checkOutput("t5_rvalid", 64'(RVALID), 64'd1);
      checkOutput("t5_rresp", 64'(RRESP), 64'd2);
      checkOutput("t5_rid", 64'(RID), 64'd4);
      checkOutput("t5_rdata", RDATA, 64'd0);
      checkOutput("t5_rlast", 64'(RLAST), (b == 2) ? 64'd1 : 64'd0);
      checkOutput("t5_arready_resp", 64'(ARREADY), 64'd0);
      if (b == 2) begin
        ARVALID = 1'b0;
      end
      tick();
    end
    checkOutput("t5_arready_back", 64'(ARREADY), 64'd1);

    // 6: reset in the middle of a long burst, then a fresh request
    applyStimulus(4'd6, 64'h8000_0200, 8'd7, 3'd3, 2'b01);
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    checkOutput("t6_b2_rvalid", 64'(RVALID), 64'd1);
    checkOutput("t6_b2_rdata", RDATA, memFn(64'h8000_0210));
    rstn = 1'b0;
    tick();
    checkOutput("t6_rst_rvalid", 64'(RVALID), 64'd0);
    checkOutput("t6_rst_arready", 64'(ARREADY), 64'd0);
    checkOutput("t6_rst_rlast", 64'(RLAST), 64'd0);
    checkOutput("t6_rst_memren", 64'(mem_ren), 64'd0);
    rstn = 1'b1;
    tick();
    checkOutput("t6_rel_arready", 64'(ARREADY), 64'd1);
    RREADY = 1'b0;
    applyStimulus(4'hA, 64'h8000_0040, 8'd0, 3'd3, 2'b01);
    tick(); tick();
    checkOutput("t6_new_memren", 64'(mem_ren), 64'd1);
    checkOutput("t6_new_addr", mem_addr, 64'h8000_0040);
    tick();
    checkOutput("t6_new_rvalid", 64'(RVALID), 64'd1);
    checkOutput("t6_new_rid", 64'(RID), 64'hA);
    checkOutput("t6_new_rdata", RDATA, memFn(64'h8000_0040));
    checkOutput("t6_new_rlast", 64'(RLAST), 64'd1);
    RREADY = 1'b1;
    tick();
    checkOutput("t6_new_arready", 64'(ARREADY), 64'd1);

    // 7: FIXED burst keeps the same beat address
    applyStimulus(4'hB, 64'h8000_0044, 8'd1, 3'd2, 2'b00);
    tick(); tick();
    checkOutput("t7_b0_addr", mem_addr, 64'h8000_0040);
    checkOutput("t7_b0_memren", 64'(mem_ren), 64'd1);
    tick();
    checkOutput("t7_b0_rlast", 64'(RLAST), 64'd0);
    checkOutput("t7_b0_rdata", RDATA, memFn(64'h8000_0040));
    tick();
    checkOutput("t7_b1_addr", mem_addr, 64'h8000_0040);
    checkOutput("t7_b1_memren", 64'(mem_ren), 64'd1);
    tick();
    checkOutput("t7_b1_rlast", 64'(RLAST), 64'd1);
    checkOutput("t7_b1_rdata", RDATA, memFn(64'h8000_0040));
    tick();
    checkOutput("t7_arready", 64'(ARREADY), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
